// File: rtl/seg7_scan_if.sv
// seg7_scan_if: display-register side and pin side of the scanner.
// master owns the display data, slave owns the pin outputs.
interface seg7_scan_if #(
  parameter int NUM_DIGITS = 8,
  parameter int PWM_BITS   = 4
);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    load_i;
  logic [4*NUM_DIGITS-1:0] data_i;
  logic [7*NUM_DIGITS-1:0] raw_i;
  logic [NUM_DIGITS-1:0]   raw_sel_i;
  logic [NUM_DIGITS-1:0]   dp_i;
  logic [NUM_DIGITS-1:0]   blank_i;
  logic [PWM_BITS-1:0]     bright_i;
  logic [7:0]              seg_o;
  logic [NUM_DIGITS-1:0]   an_o;
  logic [DW-1:0]           digit_o;
  logic                    frame_tick_o;

  modport master (
    output load_i, data_i, raw_i, raw_sel_i,
    output dp_i, blank_i, bright_i,
    input  seg_o, an_o, digit_o, frame_tick_o
  );

  modport slave (
    input  load_i, data_i, raw_i, raw_sel_i,
    input  dp_i, blank_i, bright_i,
    output seg_o, an_o, digit_o, frame_tick_o
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-segment scanner with PWM
// brightness, dead time and frame-synchronous data updates.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV       = 200000,
  parameter int PWM_BITS       = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic        clk,
  input  logic        rst,
  seg7_scan_if.slave  bus
);

  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIGITS - 1);

  localparam logic [7:0] SEG_INV =
    (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_INV =
    (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

  generate
    if (SCAN_DIV < 2) begin : g_bad_div
      $error("seg7_scan_ctrl: SCAN_DIV must be >= 2");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_n
      $error("seg7_scan_ctrl: NUM_DIGITS must be 1..16");
    end
  endgenerate

  // scan and pwm counters
  logic [SW-1:0]       slot_cnt;
  logic [DW-1:0]       digit_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;

  // shadow set, written by load_i
  logic [4*NUM_DIGITS-1:0] sh_data;
  logic [7*NUM_DIGITS-1:0] sh_raw;
  logic [NUM_DIGITS-1:0]   sh_rsel;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blank;
  logic [PWM_BITS-1:0]     sh_bright;

  // active set, what the display actually shows
  logic [4*NUM_DIGITS-1:0] act_data;
  logic [7*NUM_DIGITS-1:0] act_raw;
  logic [NUM_DIGITS-1:0]   act_rsel;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic [NUM_DIGITS-1:0]   act_blank;
  logic [PWM_BITS-1:0]     act_bright;

  // registered outputs
  logic [7:0]            seg_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic [DW-1:0]         digit_q;
  logic                  tick_q;

  logic                  slot_wrap;
  logic                  frame_wrap;
  logic [3:0]            cur_nib;
  logic [6:0]            cur_raw;
  logic                  cur_rsel;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [7:0]            cur_seg;
  logic                  pwm_on;
  logic                  an_en;
  logic [NUM_DIGITS-1:0] onehot;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'h7E;
      4'h1:    hex7 = 7'h30;
      4'h2:    hex7 = 7'h6D;
      4'h3:    hex7 = 7'h79;
      4'h4:    hex7 = 7'h33;
      4'h5:    hex7 = 7'h5B;
      4'h6:    hex7 = 7'h5F;
      4'h7:    hex7 = 7'h70;
      4'h8:    hex7 = 7'h7F;
      4'h9:    hex7 = 7'h7B;
      4'hA:    hex7 = 7'h77;
      4'hB:    hex7 = 7'h1F;
      4'hC:    hex7 = 7'h4E;
      4'hD:    hex7 = 7'h3D;
      4'hE:    hex7 = 7'h4F;
      default: hex7 = 7'h47;
    endcase
  endfunction

  assign slot_wrap  = (slot_cnt == SLOT_LAST);
  assign frame_wrap = slot_wrap && (digit_cnt == DIG_LAST);

  // slot, digit and pwm counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt  <= '0;
      digit_cnt <= '0;
      pwm_cnt   <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (slot_wrap) begin
        slot_cnt <= '0;
        if (digit_cnt == DIG_LAST) begin
          digit_cnt <= '0;
        end else begin
          digit_cnt <= digit_cnt + DW'(1);
        end
      end else begin
        slot_cnt <= slot_cnt + SW'(1);
      end
    end
  end

  // shadow capture on load_i
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_data   <= '0;
      sh_raw    <= '0;
      sh_rsel   <= '0;
      sh_dp     <= '0;
      sh_blank  <= '0;
      sh_bright <= '0;
    end else if (bus.load_i) begin
      sh_data   <= bus.data_i;
      sh_raw    <= bus.raw_i;
      sh_rsel   <= bus.raw_sel_i;
      sh_dp     <= bus.dp_i;
      sh_blank  <= bus.blank_i;
      sh_bright <= bus.bright_i;
    end
  end

  // active set follows the pre-load shadow at frame wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_data   <= '0;
      act_raw    <= '0;
      act_rsel   <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
      act_bright <= '0;
    end else if (frame_wrap) begin
      act_data   <= sh_data;
      act_raw    <= sh_raw;
      act_rsel   <= sh_rsel;
      act_dp     <= sh_dp;
      act_blank  <= sh_blank;
      act_bright <= sh_bright;
    end
  end

  // pick the fields of the digit being scanned
  always_comb begin
    cur_nib   = '0;
    cur_raw   = '0;
    cur_rsel  = 1'b0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_cnt == DW'(k)) begin
        cur_nib   = act_data[4*k +: 4];
        cur_raw   = act_raw[7*k +: 7];
        cur_rsel  = act_rsel[k];
        cur_dp    = act_dp[k];
        cur_blank = act_blank[k];
      end
    end
  end

  // pattern, brightness gate and anode enable
  always_comb begin
    cur_seg = {cur_dp, cur_rsel ? cur_raw : hex7(cur_nib)};
    pwm_on  = (&act_bright) || (pwm_cnt < act_bright);
    an_en   = (slot_cnt != '0) && pwm_on && !cur_blank;
    onehot  = NUM_DIGITS'(1) << digit_cnt;
  end

  // output register, polarity applied here last
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q   <= SEG_INV;
      an_q    <= AN_INV;
      digit_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      seg_q   <= (an_en ? cur_seg : 8'h00) ^ SEG_INV;
      an_q    <= (an_en ? onehot : '0) ^ AN_INV;
      digit_q <= digit_cnt;
      tick_q  <= frame_wrap;
    end
  end

  assign bus.seg_o        = seg_q;
  assign bus.an_o         = an_q;
  assign bus.digit_o      = digit_q;
  assign bus.frame_tick_o = tick_q;

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Parametrised, time-multiplexed 7-segment display scanner for the SoC top level. It drives N common-anode or common-cathode digits from a latched data word. Each digit can select hex decode or raw segment patterns, and has its own decimal point and blank control. The block adds global PWM brightness, anti-ghost dead time and tear-free frame-synchronous updates. It sits between the GPIO/bus-visible display register and the board segment/anode pins.

## Interface
Parameters:
- NUM_DIGITS, 8, number of multiplexed digits (1..16)
- SCAN_DIV, 200000, clk cycles per digit slot (>=2; elaboration error otherwise)
- PWM_BITS, 4, brightness resolution
- SEG_ACTIVE_LOW, 1, 1 = segment outputs inverted (lit = 0)
- AN_ACTIVE_LOW, 1, 1 = anode outputs inverted (selected = 0)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- load_i  in  1  capture all display inputs into the shadow registers this cycle
- data_i  in  4*NUM_DIGITS  hex nibbles; digit k = data_i[4k+3:4k], digit 0 rightmost
- raw_i  in  7*NUM_DIGITS  raw segment patterns {a,b,c,d,e,f,g}, digit k = raw_i[7k+6:7k]
- raw_sel_i  in  NUM_DIGITS  1 = digit k shows raw_i, 0 = hex decode of data_i
- dp_i  in  NUM_DIGITS  decimal point per digit (1 = lit)
- blank_i  in  NUM_DIGITS  1 = digit k fully dark
- bright_i  in  PWM_BITS  global brightness; sampled with load_i
- seg_o  out  8  {dp,a,b,c,d,e,f,g}, polarity per SEG_ACTIVE_LOW
- an_o  out  NUM_DIGITS  one-hot digit select, polarity per AN_ACTIVE_LOW
- digit_o  out  $clog2(NUM_DIGITS) (min 1)  index of the digit currently scanned
- frame_tick_o  out  1  one-cycle pulse at the start of each frame (digit 0 slot)

## Operation
- Shadow registers: load_i=1 copies data_i, raw_i, raw_sel_i, dp_i, blank_i and bright_i into the shadow set. Shadow contents never affect the outputs directly.
- Active set: copied from the shadow set at each frame boundary, on the cycle slot_cnt wraps from the last digit to digit 0.
- load_i on the same cycle as a frame boundary: the active set takes the pre-load shadow contents; the new values appear at the next frame.
- slot_cnt: counts 0..SCAN_DIV-1, then wraps to 0. On wrap, digit_cnt advances by 1, and from NUM_DIGITS-1 it wraps to 0.
- frame_tick: asserted when digit_cnt wraps to 0.
- Hex decode, pattern {a..g}: 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47.
- Segment selection: the pattern for the current digit is raw_i or the hex decode, per raw_sel; dp is appended as the MSB.
- pwm_cnt: PWM_BITS-bit free-running counter, incremented every cycle and wrapping.
- pwm_on: 1 when bright == all-ones, or when pwm_cnt < bright. bright = 0 means the display is dark.
- Anode enable for the current digit requires all of:
  - slot_cnt != 0 (one dead-time cycle per slot)
  - pwm_on
  - the digit's blank bit is clear
- When the anode is disabled, all anodes are inactive and seg_o is all-unlit.
- Polarity: inversion is applied last, in the output register.

## Timing
- All outputs are registered. seg_o, an_o and digit_o reflect digit_cnt/slot_cnt with exactly 1 cycle latency.
- On a digit change, seg_o and an_o update in the same cycle. Because of the dead-time cycle, the anodes are inactive for that cycle.
- Reset values (asynchronous, immediate):
  - counters, shadow set and active set = 0
  - digit_o = 0, frame_tick_o = 0
  - an_o = all inactive (all-ones if AN_ACTIVE_LOW)
  - seg_o = all unlit (0xFF if SEG_ACTIVE_LOW)
- After rst deasserts: the first slot is digit 0, and the first frame_tick_o occurs NUM_DIGITS*SCAN_DIV cycles later.
- Frame length: NUM_DIGITS*SCAN_DIV cycles. Digits with blank=1 still consume their slot.
- Reset mid-frame: the scan restarts at digit 0 and all loaded data is lost. The display remains dark (bright=0) until load_i is asserted and a frame boundary passes.
- load_i held high continuously: the shadow set tracks the inputs every cycle, and the active set samples them once per frame.

## Test plan
- Scan order (NUM_DIGITS=4, SCAN_DIV=4, PWM_BITS=2, active-low):
  - stimulus: load data_i=0x3210, bright_i=3, then wait for a frame_tick
  - required: an_o sequence 1111, 1110×3, 1111, 1101×3, …; seg_o during digit 0 = ~7E, during digit 1 = ~30
  - required: frame_tick_o every 16 cycles
- Tear-free update:
  - stimulus: load 0xAAAA, then mid-frame load 0x5555
  - required: digits of the current frame all show A (~77); the next frame all show 5 (~5B)
  - stimulus: load asserted exactly on the wrap cycle
  - required: the new value is deferred one frame
- Raw/dp/blank:
  - stimulus: raw_sel=0001, raw_i digit0=7'h01; dp_i=0010; blank_i=0100
  - required: digit0 seg_o=~01; digit1 shows the hex value with bit7 lit; digit2 an_o stays 1111 for its whole slot
- Brightness:
  - stimulus: bright=1, PWM_BITS=2
  - required: the anode is active on 1 of every 4 cycles (pwm_cnt=0), excluding dead time
  - stimulus: bright=0
  - required: an_o never active
  - stimulus: bright=3
  - required: the anode is active on every non-dead-time cycle
- Reset:
  - stimulus: assert rst during digit 2
  - required: outputs go immediately to reset values; after release, digit_o=0; an_o remains inactive until a load and a frame boundary
- Polarity:
  - stimulus: SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=0, data 8
  - required: seg_o=0x7F and an_o=0001 during digit 0
